// File: rtl/sprite_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sprite_pkg : shared encodings and widths for the sprite motion engine     |
// | Revision   : 1.0 - initial release                                         |
// +---------------------------------------------------------------------------+
package sprite_pkg;

   // bit1: 0 = down, 1 = up; bit0: 0 = right, 1 = left
   typedef enum logic [1:0] {
      DIR_RD = 2'b00,
      DIR_LD = 2'b01,
      DIR_RU = 2'b10,
      DIR_LU = 2'b11
   } dir_t;

   localparam int DEF_SCR_W = 640;
   localparam int DEF_SCR_H = 480;
   localparam int POS_W     = 10;
   localparam int LVL_W     = 3;

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/sprite_axis_step.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sprite_axis_step : saturating step of a position within [0, limit]        |
// |                    with a turn flag when the range edge is reached        |
// | Revision         : 1.0 - initial release                                   |
// +---------------------------------------------------------------------------+
module sprite_axis_step #(
   parameter int W         = 10,
   // 1: reaching an edge exactly counts as a turn; 0: only overshooting does
   parameter bit INCLUSIVE = 1'b1
)(
   input  logic [W-1:0] pos,
   input  logic [W-1:0] step,
   input  logic [W-1:0] limit,
   input  logic         dec,
   output logic [W-1:0] next_pos,
   output logic         turn
);

   logic [W:0] w_pos;
   logic [W:0] w_step;
   logic [W:0] w_limit;
   logic [W:0] w_sum;
   logic       w_hi_hit;
   logic       w_lo_hit;

   always_comb begin
      w_pos    = {1'b0, pos};
      w_step   = {1'b0, step};
      w_limit  = {1'b0, limit};
      w_sum    = w_pos + w_step;
      w_hi_hit = INCLUSIVE ? (w_sum >= w_limit) : (w_sum > w_limit);
      w_lo_hit = INCLUSIVE ? (w_pos <= w_step)  : (w_pos < w_step);
      next_pos = pos;
      turn     = 1'b0;
      if (dec) begin
         if (w_lo_hit) begin
            next_pos = '0;
            turn     = 1'b1;
         end else begin
            next_pos = W'(w_pos - w_step);
         end
      end else begin
         if (w_hi_hit) begin
            next_pos = limit;
            turn     = 1'b1;
         end else begin
            next_pos = W'(w_sum);
         end
      end
   end

endmodule : sprite_axis_step
`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sprite_motion_ctrl : per-frame position/direction/speed/animation engine  |
// |                      for one sprite; SPRITE_MOTION_ANIM_EN builds anim    |
// | Revision           : 1.0 - initial release                                 |
// +---------------------------------------------------------------------------+
module sprite_motion_ctrl
   import sprite_pkg::*;
#(
   parameter int SCR_W     = DEF_SCR_W,
   parameter int SCR_H     = DEF_SCR_H,
   parameter int SPR_W     = 64,
   parameter int SPR_H     = 32,
   parameter int INIT_X    = 0,
   parameter int INIT_Y    = 200,
   parameter int ROW_STEP  = 8,
   parameter int JUMP      = 32,
   parameter int MAX_LEVEL = 4
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run,
   input  logic             frame_sync,
   input  logic             speed_step,
   input  logic             catch,
   output logic [POS_W-1:0] spr_x,
   output logic [POS_W-1:0] spr_y,
   output logic [1:0]       spr_dir,
   output logic [LVL_W-1:0] speed_level,
   output logic [2:0]       anim_frame
);

   localparam logic [POS_W-1:0] c_x_max     = POS_W'(SCR_W - SPR_W);
   localparam logic [POS_W-1:0] c_y_max     = POS_W'(SCR_H - SPR_H);
   localparam logic [POS_W-1:0] c_row_step  = POS_W'(ROW_STEP);
   localparam logic [POS_W-1:0] c_jump      = POS_W'(JUMP);
   localparam logic [POS_W-1:0] c_init_x    = POS_W'(INIT_X);
   localparam logic [POS_W-1:0] c_init_y    = POS_W'(INIT_Y);
   localparam logic [LVL_W-1:0] c_max_level = LVL_W'(MAX_LEVEL);

   logic [POS_W-1:0] r_x;
   logic [POS_W-1:0] r_y;
   dir_t             r_dir;
   logic [LVL_W-1:0] r_level;
   logic             r_pend;

   logic             w_update;
   logic             w_lift;
   logic [POS_W-1:0] w_speed;
   logic [POS_W-1:0] w_y_step;
   logic             w_y_dec;
   logic [POS_W-1:0] w_x_next;
   logic             w_x_turn;
   logic [POS_W-1:0] w_y_next;
   logic             w_y_turn;

   // A catch arriving with the frame pulse is folded into that same update.
   always_comb begin
      w_update = frame_sync & run;
      w_lift   = r_pend | catch;
      w_speed  = POS_W'(r_level) + POS_W'(1);
      w_y_step = w_lift ? c_jump : c_row_step;
      w_y_dec  = w_lift | r_dir[1];
   end

   sprite_axis_step #(
      .W         (POS_W),
      .INCLUSIVE (1'b1)
   ) u_x_axis (
      .pos      (r_x),
      .step     (w_speed),
      .limit    (c_x_max),
      .dec      (r_dir[0]),
      .next_pos (w_x_next),
      .turn     (w_x_turn)
   );

   // The y axis serves both the row step at a turn and the upward catch lift.
   sprite_axis_step #(
      .W         (POS_W),
      .INCLUSIVE (1'b0)
   ) u_y_axis (
      .pos      (r_y),
      .step     (w_y_step),
      .limit    (c_y_max),
      .dec      (w_y_dec),
      .next_pos (w_y_next),
      .turn     (w_y_turn)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_x     <= c_init_x;
         r_y     <= c_init_y;
         r_dir   <= DIR_RD;
         r_level <= '0;
         r_pend  <= 1'b0;
      end else begin
         if (speed_step) begin
            r_level <= (r_level == c_max_level) ? '0 : r_level + 1'b1;
         end
         if (w_update) begin
            r_pend <= 1'b0;
            if (w_lift) begin
               r_y <= w_y_next;
            end else begin
               r_x <= w_x_next;
               if (w_x_turn) begin
                  r_y   <= w_y_next;
                  r_dir <= dir_t'({r_dir[1] ^ w_y_turn, ~r_dir[0]});
               end
            end
         end else if (catch) begin
            r_pend <= 1'b1;
         end
      end
   end

   assign spr_x       = r_x;
   assign spr_y       = r_y;
   assign spr_dir     = r_dir;
   assign speed_level = r_level;

`ifdef SPRITE_MOTION_ANIM_EN
   logic       r_anim_tgl;
   logic [2:0] r_anim;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_anim_tgl <= 1'b0;
         r_anim     <= 3'd0;
      end else if (w_update) begin
         r_anim_tgl <= ~r_anim_tgl;
         if (r_anim_tgl) begin
            r_anim <= r_anim + 3'd1;
         end
      end
   end

   assign anim_frame = r_anim;
`else
   assign anim_frame = 3'd0;
`endif

endmodule : sprite_motion_ctrl
`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_sprite_motion_ctrl : directed self-checking bench for sprite motion    |
// | Revision              : 1.0 - initial release                              |
// +---------------------------------------------------------------------------+
module tb_sprite_motion_ctrl;

`ifdef SPRITE_MOTION_ANIM_EN
   localparam bit c_anim_en = 1'b1;
`else
   localparam bit c_anim_en = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       run;
   logic       frame_sync;
   logic       speed_step;
   logic       catch;
   logic [9:0] spr_x;
   logic [9:0] spr_y;
   logic [1:0] spr_dir;
   logic [2:0] speed_level;
   logic [2:0] anim_frame;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       rn;
      logic       run;
      logic       fs;
      logic       ss;
      logic       ct;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] dir;
      logic [2:0] lvl;
      logic [2:0] anim;
   } vec_t;

   vec_t tbl [26];

   always #5 clk = ~clk;

   sprite_motion_ctrl u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .run         (run),
      .frame_sync  (frame_sync),
      .speed_step  (speed_step),
      .catch       (catch),
      .spr_x       (spr_x),
      .spr_y       (spr_y),
      .spr_dir     (spr_dir),
      .speed_level (speed_level),
      .anim_frame  (anim_frame)
   );

   function automatic vec_t mk(input logic rn, input logic r, input logic fs,
                               input logic ss, input logic ct, input int x,
                               input int y, input int dir, input int lvl,
                               input int anim);
      vec_t v;
      v.rn   = rn;
      v.run  = r;
      v.fs   = fs;
      v.ss   = ss;
      v.ct   = ct;
      v.x    = 10'(x);
      v.y    = 10'(y);
      v.dir  = 2'(dir);
      v.lvl  = 3'(lvl);
      v.anim = 3'(anim);
      return v;
   endfunction

   // anim values are written for the animated build; without it the index stays 0
   function automatic int exp_anim(input int v);
      return c_anim_en ? (v % 8) : 0;
   endfunction

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check(input string tag, input int x, input int y, input int dir,
                        input int lvl, input int anim);
      cmp({tag, " spr_x"}, int'(spr_x), x);
      cmp({tag, " spr_y"}, int'(spr_y), y);
      cmp({tag, " spr_dir"}, int'(spr_dir), dir);
      cmp({tag, " speed_level"}, int'(speed_level), lvl);
      cmp({tag, " anim_frame"}, int'(anim_frame), exp_anim(anim));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_sync = 1'b1;
         tick();
         frame_sync = 1'b0;
         tick();
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) begin
         speed_step = 1'b1;
         tick();
         speed_step = 1'b0;
         tick();
      end
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      run        = 1'b0;
      frame_sync = 1'b0;
      speed_step = 1'b0;
      catch      = 1'b0;
      tick();
      reset_n    = 1'b1;
   endtask

   initial begin
      //             rn  run fs  ss  ct    x    y  dir lvl anim
      tbl[0]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,  0, 200, 0, 0, 0);
      tbl[1]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,  0, 200, 0, 1, 0);
      tbl[2]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,  0, 200, 0, 2, 0);
      tbl[3]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,  0, 200, 0, 3, 0);
      tbl[4]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,  0, 200, 0, 4, 0);
      tbl[5]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,  0, 200, 0, 0, 0);
      tbl[6]  = mk(1'b1,1'b0,1'b0,1'b1,1'b0,  0, 200, 0, 1, 0);
      // step with frame: move uses old speed 2, level becomes 2
      tbl[7]  = mk(1'b1,1'b1,1'b1,1'b1,1'b0,  2, 200, 0, 2, 0);
      tbl[8]  = mk(1'b1,1'b1,1'b1,1'b0,1'b0,  5, 200, 0, 2, 1);
      // run low: frames ignored, catch held pending
      tbl[9]  = mk(1'b1,1'b0,1'b1,1'b0,1'b0,  5, 200, 0, 2, 1);
      tbl[10] = mk(1'b1,1'b0,1'b1,1'b0,1'b1,  5, 200, 0, 2, 1);
      tbl[11] = mk(1'b1,1'b0,1'b1,1'b0,1'b0,  5, 200, 0, 2, 1);
      tbl[12] = mk(1'b1,1'b1,1'b1,1'b0,1'b0,  5, 168, 0, 2, 1);
      // two catches collapse into one lift
      tbl[13] = mk(1'b1,1'b1,1'b0,1'b0,1'b1,  5, 168, 0, 2, 1);
      tbl[14] = mk(1'b1,1'b1,1'b0,1'b0,1'b1,  5, 168, 0, 2, 1);
      tbl[15] = mk(1'b1,1'b1,1'b1,1'b0,1'b0,  5, 136, 0, 2, 2);
      tbl[16] = mk(1'b1,1'b1,1'b1,1'b0,1'b0,  8, 136, 0, 2, 2);
      tbl[17] = mk(1'b1,1'b1,1'b1,1'b0,1'b1,  8, 104, 0, 2, 3);
      tbl[18] = mk(1'b1,1'b1,1'b1,1'b0,1'b1,  8,  72, 0, 2, 3);
      tbl[19] = mk(1'b1,1'b1,1'b1,1'b0,1'b1,  8,  40, 0, 2, 4);
      tbl[20] = mk(1'b1,1'b1,1'b1,1'b0,1'b1,  8,   8, 0, 2, 4);
      tbl[21] = mk(1'b1,1'b1,1'b1,1'b0,1'b1,  8,   0, 0, 2, 5);
      tbl[22] = mk(1'b1,1'b1,1'b1,1'b0,1'b0, 11,   0, 0, 2, 5);
      // reset wins over every other input, and the catch is not latched
      tbl[23] = mk(1'b0,1'b1,1'b1,1'b1,1'b1,  0, 200, 0, 0, 0);
      tbl[24] = mk(1'b1,1'b1,1'b1,1'b0,1'b0,  1, 200, 0, 0, 0);
      tbl[25] = mk(1'b1,1'b1,1'b1,1'b0,1'b0,  2, 200, 0, 0, 1);

      do_reset();
      check("reset", 0, 200, 0, 0, 0);

      for (int i = 0; i < 26; i++) begin
         reset_n    = tbl[i].rn;
         run        = tbl[i].run;
         frame_sync = tbl[i].fs;
         speed_step = tbl[i].ss;
         catch      = tbl[i].ct;
         tick();
         check($sformatf("row%0d", i), int'(tbl[i].x), int'(tbl[i].y),
               int'(tbl[i].dir), int'(tbl[i].lvl), int'(tbl[i].anim));
      end

      // level 0 sweep to the right edge and first turn
      do_reset();
      run = 1'b1;
      frames(10);
      check("sweep10", 10, 200, 0, 0, 5);
      frames(565);
      check("sweep575", 575, 200, 0, 0, 7);
      frames(1);
      check("rturn", 576, 208, 1, 0, 0);

      // level 4 speed
      do_reset();
      steps(4);
      run = 1'b1;
      frames(20);
      check("lvl4_100", 100, 200, 0, 4, 2);
      frames(1);
      check("lvl4_105", 105, 200, 0, 4, 2);

      // 31 passes of 116 frames each bring y to the bottom edge
      do_reset();
      steps(4);
      run = 1'b1;
      frames(31 * 116);
      check("bottom", 576, 448, 1, 4, 6);
      frames(115);
      check("left1", 1, 448, 1, 4, 7);
      steps(1);
      frames(1);
      check("lturn_clamp", 0, 448, 2, 0, 0);

      run = 1'b0;
      frames(3);
      check("run_off", 0, 448, 2, 0, 0);

      run        = 1'b1;
      reset_n    = 1'b0;
      frame_sync = 1'b1;
      tick();
      reset_n    = 1'b1;
      frame_sync = 1'b0;
      check("mid_reset", 0, 200, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_sprite_motion_ctrl
`default_nettype wire

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Per-frame motion engine for one animated sprite in the VGA scene. Once per video frame it updates the sprite's top-left screen position, swim direction, speed level and animation frame index. The downstream renderer/compositor consumes these registered values to form sprite ROM addresses and the region test. Speed is cycled by a debounced button pulse, and a "catch" event lifts the sprite toward the surface.

## Interface
- SCR_W, 640: screen width in pixels.
- SCR_H, 480: screen height in pixels.
- SPR_W, 64: sprite width on screen.
- SPR_H, 32: sprite height on screen.
- INIT_X, 0: reset x position.
- INIT_Y, 200: reset y position.
- ROW_STEP, 8: vertical step applied at each horizontal turn.
- JUMP, 32: upward lift applied per catch.
- MAX_LEVEL, 4: highest speed level; speed = level+1 px/frame.
- clk  in  1  system clock; the single clock of the block.
- reset_n  in  1  synchronous, active-low reset.
- run  in  1  motion enable (high once sprite ROM loading is done).
- frame_sync  in  1  one-cycle pulse per frame, issued during vertical blanking.
- speed_step  in  1  one-cycle debounced button-press pulse.
- catch  in  1  one-cycle catch event pulse; may occur on any cycle.
- spr_x  out  10  sprite left column, 0..SCR_W-SPR_W.
- spr_y  out  10  sprite top row, 0..SCR_H-SPR_H.
- spr_dir  out  2  bit1: 0 = down, 1 = up; bit0: 0 = right, 1 = left (renderer mirrors when bit0 = 1).
- speed_level  out  3  0..MAX_LEVEL.
- anim_frame  out  3  animation image index 0..7.

## Operation
- Reset values: spr_x=INIT_X, spr_y=INIT_Y, spr_dir=2'b00, speed_level=0, anim_frame=0. The internal catch_pend flag and the frame toggle are cleared.
- speed_step: speed_level increments; MAX_LEVEL wraps to 0. It is accepted regardless of run.
- catch: sets catch_pend. catch_pend is cleared only when consumed by a frame update.
- Frame update occurs when frame_sync=1 and run=1. When run=0, frame_sync is ignored and catch_pend is kept.
- Frame update with catch_pend=1:
  - spr_y ← max(spr_y−JUMP, 0).
  - No horizontal move.
  - catch_pend cleared.
  - spr_dir unchanged.
- Frame update otherwise, with s = speed_level+1:
  - Right (bit0=0): if spr_x+s ≥ SCR_W−SPR_W, then spr_x ← SCR_W−SPR_W, bit0 ← 1, and a vertical step is applied. Else spr_x += s.
  - Left (bit0=1): if spr_x ≤ s, then spr_x ← 0, bit0 ← 0, and a vertical step is applied. Else spr_x −= s.
- Vertical step:
  - Down: if spr_y+ROW_STEP > SCR_H−SPR_H, then spr_y ← SCR_H−SPR_H and bit1 ← 1. Else spr_y += ROW_STEP.
  - Up: if spr_y < ROW_STEP, then spr_y ← 0 and bit1 ← 0. Else spr_y −= ROW_STEP.
- Arithmetic is done at 11 bits internally, so there is no wrap; results are clamped before registering.
- anim_frame: advances once every 2 frame updates (frame toggle) and wraps 7→0.

## Timing
- All outputs are registered. A frame update samples frame_sync at edge N; new values are visible after edge N and are stable for the entire active video.
- speed_step coincident with frame_sync: that update uses the old speed; the new level applies from the next frame.
- catch coincident with frame_sync: it is consumed by that same update.
- Multiple catch pulses between frames collapse into a single lift.
- reset_n low on any edge forces the reset values at that edge, overriding all other inputs, including mid-turn.

## Configuration
- SPRITE_MOTION_ANIM_EN defined: the anim_frame counter and frame toggle are built as described above.
- SPRITE_MOTION_ANIM_EN undefined: anim_frame is tied to 3'd0 and the counter logic is removed. Motion behaviour is identical.

## Structure
- Shared package sprite_pkg holds:
  - Direction encodings: DIR_RD=2'b00, DIR_LD=2'b01, DIR_RU=2'b10, DIR_LU=2'b11.
  - SCR_W/SCR_H defaults.
  - Speed-level width.
- One sub-module, sprite_axis_step: a saturating add/subtract of a step against a [0, limit] range, with a turn-flag output. It is instantiated twice, once for the x axis and once for the y axis.

## Test plan
- Reset, then run=1 and 10 frame_sync pulses at level 0 → spr_x=10, spr_y=200, spr_dir=00, anim_frame=5.
- spr_x=575, dir 00, level 0, one frame → spr_x=576, spr_dir=01, spr_y=208.
- spr_y=448, spr_x=1, dir 01, level 0, one frame → spr_x=0, spr_y=448, spr_dir=10.
- 5 speed_step pulses → speed_level steps 1,2,3,4,0. Then at level 4 with spr_x=100, dir 00, one frame → spr_x=105.
- catch at spr_y=20, then next frame → spr_y=0 and spr_x unchanged. Two catches before one frame at spr_y=200 → spr_y=168.
- run=0 with 3 frame_sync pulses → outputs unchanged. reset_n low for one cycle mid-motion → all outputs return to their reset values.
